// File: rtl/fm_out_pkg.sv
// fm_out_pkg: shared constants for the fm_out FM square-wave generator.
package fm_out_pkg;

  localparam int         CNT_W_DEF = 16;
  localparam logic [7:0] DATA_MID  = 8'd128;
  localparam int         MIN_HALF  = 2;

endpackage

// File: rtl/fm_out_period_meter.sv
// fm_out_period_meter: synchronizes the centre reference and measures its period in clk cycles.
// With FM_OUT_AVG_EN defined the reported period is a running average of successive measurements.
module fm_out_period_meter
  import fm_out_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             centre_i,
  output logic [CNT_W-1:0] centre_period_o,
  output logic             valid_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // sync_q[1:0] is the synchronizer, sync_q[2] the previous synchronized level
  logic [2:0]       sync_q;
  logic             seen_q, seen_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             rise_s;

  assign rise_s = sync_q[1] & ~sync_q[2];

  // next-state: the first edge only arms the counter, later edges publish a period
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    seen_d   = seen_q;
    valid_d  = valid_q;
    if (rise_s) begin
      seen_d = 1'b1;
      cnt_d  = CNT_ONE;
      if (seen_q) begin
        valid_d = 1'b1;
`ifdef FM_OUT_AVG_EN
        if (valid_q) begin
          period_d = CNT_W'(({1'b0, period_q} + {1'b0, cnt_q}) >> 1);
        end else begin
          period_d = cnt_q;
        end
`else
        period_d = cnt_q;
`endif
      end else begin
        period_d = period_q;
      end
    end else if (seen_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 3'b000;
      seen_q   <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      sync_q   <= {sync_q[1:0], centre_i};
      seen_q   <= seen_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign centre_period_o = period_q;
  assign valid_o         = valid_q;

endmodule

// File: rtl/fm_out.sv
// fm_out: frequency-modulated square wave whose carrier half-period follows the measured centre period.
// Optional macro FM_OUT_AVG_EN enables centre-period averaging in fm_out_period_meter.
module fm_out
  import fm_out_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DEV_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       centre,
  input  logic       update,
  input  logic [7:0] data,
  output logic       fm
);

  localparam int                   W2      = CNT_W + 10;
  localparam logic signed [W2-1:0] HALF_LO = W2'(MIN_HALF);
  localparam logic signed [W2-1:0] HALF_HI = {{10{1'b0}}, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]     centre_period_s;
  logic                 valid_s;
  logic                 upd_q, upd_d;
  logic [7:0]           data_reg_q, data_reg_d;
  logic                 valid_prev_q;
  logic                 fm_q, fm_d;
  logic [CNT_W-1:0]     hcnt_q, hcnt_d;
  logic [CNT_W-1:0]     tgt_q, tgt_d, tgt_s;
  logic signed [8:0]    dev9_s;
  logic signed [W2-1:0] dev_s, half_s, diff_s;

  fm_out_period_meter #(.CNT_W(CNT_W)) u_meter (
    .clk             (clk),
    .rst             (rst),
    .centre_i        (centre),
    .centre_period_o (centre_period_s),
    .valid_o         (valid_s)
  );

  assign dev9_s = $signed({1'b0, data_reg_q}) - $signed({1'b0, DATA_MID});
  assign dev_s  = $signed({{(W2-9){dev9_s[8]}}, dev9_s}) <<< DEV_SHIFT;
  assign half_s = $signed({10'd0, centre_period_s}) >>> 1;

  // target half-period: higher data shortens the half-period, clamped to the counter range
  always_comb begin
    diff_s = half_s - dev_s;
    if (diff_s < HALF_LO) begin
      tgt_s = CNT_W'(MIN_HALF);
    end else if (diff_s > HALF_HI) begin
      tgt_s = {CNT_W{1'b1}};
    end else begin
      tgt_s = diff_s[CNT_W-1:0];
    end
  end

  // next-state: data capture on update rising edge, half-period counter and fm toggle
  always_comb begin
    upd_d      = update;
    data_reg_d = data_reg_q;
    hcnt_d     = hcnt_q;
    fm_d       = fm_q;
    tgt_d      = tgt_q;
    if (update && !upd_q) begin
      data_reg_d = data;
    end else begin
      data_reg_d = data_reg_q;
    end
    if (!valid_s) begin
      hcnt_d = '0;
      fm_d   = 1'b0;
    end else if (!valid_prev_q) begin
      tgt_d  = tgt_s;
      hcnt_d = CNT_ONE;
    end else if (hcnt_q == (tgt_q - CNT_ONE)) begin
      // target is only re-latched here so every half-cycle completes with one length
      fm_d   = ~fm_q;
      hcnt_d = '0;
      tgt_d  = tgt_s;
    end else begin
      hcnt_d = hcnt_q + CNT_ONE;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q        <= 1'b0;
      data_reg_q   <= DATA_MID;
      valid_prev_q <= 1'b0;
      fm_q         <= 1'b0;
      hcnt_q       <= '0;
      tgt_q        <= CNT_W'(MIN_HALF);
    end else begin
      upd_q        <= upd_d;
      data_reg_q   <= data_reg_d;
      valid_prev_q <= valid_s;
      fm_q         <= fm_d;
      hcnt_q       <= hcnt_d;
      tgt_q        <= tgt_d;
    end
  end

  assign fm = fm_q;

endmodule

// File: tb/tb_fm_out.sv
// tb_fm_out: directed self-checking bench for fm_out (default and DEV_SHIFT=4 instances).
`timescale 1ns/1ps
module tb_fm_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       centre;
  logic       update;
  logic       update4;
  logic [7:0] data;
  logic [7:0] data4;
  logic       fm;
  logic       fm4;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_half = 15000;
  int edge_total = 0;
  int edges;
  int fm_hi;
  int cyc;
  int exp_avg1;
  int exp_avg2;

  fm_out dut (
    .clk    (clk),
    .rst    (rst),
    .centre (centre),
    .update (update),
    .data   (data),
    .fm     (fm)
  );

  fm_out #(.DEV_SHIFT(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .centre (centre),
    .update (update4),
    .data   (data4),
    .fm     (fm4)
  );

  always #10 clk = ~clk;

  // centre reference; the half-period is picked up at each rising edge
  initial begin
    int h;
    forever begin
      centre = 1'b1;
      h = cur_half;
      #(h);
      centre = 1'b0;
      #(h);
    end
  end

  always @(posedge centre) edge_total = edge_total + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // release reset while centre is low so no spurious synchronized edge appears
  task automatic release_rst();
    @(negedge centre);
    #2000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n_edges, output int saw_fm);
    int base;
    bit ok;
    base    = edge_total;
    saw_fm  = 0;
    ok      = 1'b0;
    for (int i = 0; i < 10000 && !ok; i++) begin
      @(negedge clk);
      if (fm) saw_fm = 1;
      if (dut.valid_s) ok = 1'b1;
    end
    n_edges = ok ? (edge_total - base) : -1;
  endtask

  task automatic measure_half(input int sel, output int n);
    logic prev;
    logic cur;
    bit   seen;
    n    = -1;
    seen = 1'b0;
    @(negedge clk);
    prev = (sel != 0) ? fm4 : fm;
    for (int i = 0; i < 10000 && !seen; i++) begin
      @(negedge clk);
      cur = (sel != 0) ? fm4 : fm;
      if (cur != prev) seen = 1'b1;
      prev = cur;
    end
    if (seen) begin
      for (int i = 1; i <= 10000; i++) begin
        @(negedge clk);
        cur = (sel != 0) ? fm4 : fm;
        if (cur != prev) begin
          n = i;
          break;
        end
      end
    end
  endtask

  task automatic pulse(input int sel, input logic [7:0] v);
    @(negedge clk);
    if (sel != 0) begin
      data4   = v;
      update4 = 1'b1;
    end else begin
      data   = v;
      update = 1'b1;
    end
    @(negedge clk);
    update  = 1'b0;
    update4 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
`ifdef FM_OUT_AVG_EN
    exp_avg1 = 1250;
    exp_avg2 = 1125;
`else
    exp_avg1 = 1000;
    exp_avg2 = 1000;
`endif
    rst     = 1'b1;
    update  = 1'b0;
    update4 = 1'b0;
    data    = 8'd128;
    data4   = 8'd128;
    #5;
    check_eq("rst_fm", int'(fm), 0);
    check_eq("rst_valid", int'(dut.valid_s), 0);
    check_eq("rst_period", int'(dut.centre_period_s), 0);
    check_eq("rst_data_reg", int'(dut.data_reg_q), 128);

    release_rst();
    wait_valid(edges, fm_hi);
    check_eq("valid_after_edges", edges, 2);
    check_eq("fm_quiet_before_valid", fm_hi, 0);
    check_eq("period_1500", int'(dut.centre_period_s), 1500);
    measure_half(0, cyc);
    check_eq("half_mid", cyc, 750);

    // five-cycle update with data changing mid-pulse: only the first value is taken
    @(negedge clk);
    data   = 8'd20;
    update = 1'b1;
    @(negedge clk);
    data   = 8'd99;
    repeat (4) @(negedge clk);
    update = 1'b0;
    @(negedge clk);
    check_eq("data_once", int'(dut.data_reg_q), 20);
    measure_half(0, cyc);
    check_eq("half_data20", cyc, 858);

    pulse(0, 8'd228);
    measure_half(0, cyc);
    check_eq("half_data228", cyc, 650);
    pulse(0, 8'd128);
    measure_half(0, cyc);
    check_eq("half_data128", cyc, 750);

    pulse(1, 8'd255);
    measure_half(1, cyc);
    check_eq("shift4_clamp_lo", cyc, 2);
    pulse(1, 8'd0);
    measure_half(1, cyc);
    check_eq("shift4_data0", cyc, 2798);

    // asynchronous reset in the middle of a high fm half-cycle
    pulse(0, 8'd200);
    for (int i = 0; i < 4000 && !fm; i++) @(negedge clk);
    check_eq("fm_high_before_rst", int'(fm), 1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_fm", int'(fm), 0);
    check_eq("mid_rst_data_reg", int'(dut.data_reg_q), 128);
    check_eq("mid_rst_valid", int'(dut.valid_s), 0);
    repeat (5) @(negedge clk);
    release_rst();
    wait_valid(edges, fm_hi);
    check_eq("restart_edges", edges, 2);
    check_eq("restart_fm_quiet", fm_hi, 0);

    // centre period step 1500 -> 1000 cycles
    @(posedge centre);
    #100;
    cur_half = 10000;
    @(posedge centre);
    @(posedge centre);
    repeat (10) @(negedge clk);
    check_eq("step_period1", int'(dut.centre_period_s), exp_avg1);
    @(posedge centre);
    repeat (10) @(negedge clk);
    check_eq("step_period2", int'(dut.centre_period_s), exp_avg2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
